// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Character queue between a host/bus writer and a UART transmitter.
//   First-word-fall-through: the head entry is always presented on rd_data,
//   and the transmitter's end-of-frame pulse (tx_done) pops it.
//
// Ports
//   clk          single clock, rising-edge
//   reset        asynchronous, active-high
//   wr_en        push request
//   wr_data      character to push
//   rd_en        pop request (transmitter tx_done)
//   err_clr      synchronous clear of the sticky overflow/underflow flags
//   rd_data      head character, zero while empty
//   empty        no entries stored (transmitter tx_start_n)
//   full         count == DEPTH
//   almost_full  count >= AF_LEVEL
//   count        number of stored entries
//   overflow     sticky: a push was rejected
//   underflow    sticky: a pop was rejected
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_SIZE = $clog2(DEPTH),
    parameter int AF_LEVEL  = DEPTH - 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_SIZE:0] C_DEPTH = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] C_AF    = (ADDR_SIZE+1)'(AF_LEVEL);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic w_push;
    logic w_pop;

    // Status comes only from the registered count, so there is no
    // combinational path from wr_en/rd_en to any flag.
    assign empty       = (r_count == '0);
    assign full        = (r_count == C_DEPTH);
    assign almost_full = (r_count >= C_AF);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // full is the pre-edge value: a push into a full queue is rejected even
    // when a pop frees a slot in the same cycle.
    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;

    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage is deliberately not reset; reset only empties the queue.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A rejection in the same cycle as err_clr wins, so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BAUD  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          empty, full, almost_full, overflow, underflow;
    logic [AW:0]   count;
    logic          tx_line = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data), .empty(empty),
        .full(full), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int e_empty, input int e_full,
                           input int e_af, input int e_cnt, input int e_rd,
                           input int e_ovf, input int e_udf);
        chk({tag, ".empty"}, int'(empty), e_empty);
        chk({tag, ".full"}, int'(full), e_full);
        chk({tag, ".almost_full"}, int'(almost_full), e_af);
        chk({tag, ".count"}, int'(count), e_cnt);
        chk({tag, ".rd_data"}, int'(rd_data), e_rd);
        chk({tag, ".overflow"}, int'(overflow), e_ovf);
        chk({tag, ".underflow"}, int'(underflow), e_udf);
    endtask

    // One clock with the given inputs held across the edge, then sample 1ns later.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        wr_en = w; rd_en = r; err_clr = c; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Minimal transmitter stand-in: waits for data, sends start+8 data+stop
    // LSB first, then pulses tx_done (rd_en) for one cycle.
    task automatic tx_frame(output logic [9:0] bits, output logic ok);
        logic [DW-1:0] d;
        int t;
        t = 0;
        ok = 1'b1;
        while (empty && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (empty) ok = 1'b0;
        d = rd_data;
        for (int i = 0; i < 10; i++) begin
            tx_line = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
            bits[i] = tx_line;
            repeat (BAUD) @(posedge clk);
            #1;
        end
        tx_line = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, '0);
    endtask

    typedef struct {
        logic          wr, rd, clr;
        logic [DW-1:0] d;
        logic          e_empty;
        logic [AW:0]   e_cnt;
        logic [DW-1:0] e_rd;
        logic          e_ovf, e_udf;
    } vec_t;

    vec_t tbl [10];

    logic [DW-1:0] model_q [$];
    logic          m_ovf, m_udf;

    initial begin
        logic [9:0] bits;
        logic       ok;
        logic [9:0] exp_frame;
        logic       w, r, c;
        logic [DW-1:0] d;
        int         sz;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 5'd1, 8'h55, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 5'd1, 8'h11, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 5'd2, 8'h11, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 5'd2, 8'h22, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 8'h33, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 8'h33, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1; #3;
        chk_all("reset", 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table: single push/pop, underflow + clear, same-cycle push/pop
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].d);
            chk($sformatf("vec%0d.empty", i), int'(empty), int'(tbl[i].e_empty));
            chk($sformatf("vec%0d.count", i), int'(count), int'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(tbl[i].e_rd));
            chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.underflow", i), int'(underflow), int'(tbl[i].e_udf));
        end

        // Fill to full, reject 17th push, drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, DW'(i));
        chk_all("fill16", 0, 1, 1, 16, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        chk_all("push17", 0, 1, 1, 16, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d.head", i), int'(rd_data), i);
            cyc(1'b0, 1'b1, 1'b0, '0);
        end
        chk_all("drained", 1, 0, 0, 0, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        chk("clr.overflow", int'(overflow), 0);

        // Full + push + pop: push rejected, pop still taken
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
        cyc(1'b1, 1'b1, 1'b0, 8'hBB);
        chk_all("full_wr_rd", 0, 0, 1, 15, 8'h41, 1, 0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        chk("clr2.overflow", int'(overflow), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hCC);
        // Rejection beats a same-cycle clear
        cyc(1'b1, 1'b0, 1'b1, 8'hDD);
        chk("prio.overflow", int'(overflow), 1);
        chk("prio.count", int'(count), 16);

        // almost_full threshold around 14
        do_reset();
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0, DW'(i));
        chk_all("af14", 0, 0, 1, 14, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h3C);
        chk_all("af15", 0, 0, 1, 15, 0, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk_all("af13", 0, 0, 0, 13, 2, 0, 0);

        // Randomized traffic against a queue model
        do_reset();
        model_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sz = model_q.size();
            // Bias toward filling in the first half and draining in the second
            w = ($urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 30));
            r = ($urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 75));
            c = ($urandom_range(0, 19) == 0);
            d = DW'($urandom);
            if (w && sz == DEPTH) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (r && sz == 0) m_udf = 1'b1;
            else if (c) m_udf = 1'b0;
            if (r && sz > 0) void'(model_q.pop_front());
            if (w && sz < DEPTH) model_q.push_back(d);
            cyc(w, r, c, d);
            sz = model_q.size();
            chk($sformatf("rnd%0d.count", i), int'(count), sz);
            chk($sformatf("rnd%0d.head", i), int'(rd_data), sz == 0 ? 0 : int'(model_q[0]));
            chk($sformatf("rnd%0d.full", i), int'(full), int'(sz == DEPTH));
            chk($sformatf("rnd%0d.af", i), int'(almost_full), int'(sz >= DEPTH - 2));
            chk($sformatf("rnd%0d.ovf", i), int'(overflow), int'(m_ovf));
            chk($sformatf("rnd%0d.udf", i), int'(underflow), int'(m_udf));
        end

        // Transmitter handshake: two frames, then queue empty
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        cyc(1'b1, 1'b0, 1'b0, 8'h3C);
        exp_frame = {1'b1, 8'hA5, 1'b0};
        tx_frame(bits, ok);
        chk("tx1.ready", int'(ok), 1);
        chk("tx1.frame", int'(bits), int'(exp_frame));
        chk("tx1.count", int'(count), 1);
        exp_frame = {1'b1, 8'h3C, 1'b0};
        tx_frame(bits, ok);
        chk("tx2.ready", int'(ok), 1);
        chk("tx2.frame", int'(bits), int'(exp_frame));
        chk_all("tx_done2", 1, 0, 0, 0, 0, 0, 0);

        // Reset mid-frame, asynchronous, with push/pop pending
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        cyc(1'b1, 1'b0, 1'b0, 8'h78);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 8'h79);
        repeat (2) @(posedge clk);
        #3;
        wr_en = 1'b1; rd_en = 1'b1; err_clr = 1'b1; wr_data = 8'h99;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("rst_hold", 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        // First push right after reset release is accepted
        cyc(1'b1, 1'b0, 1'b0, 8'h5A);
        chk_all("post_rst", 0, 0, 0, 1, 8'h5A, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
